tt_um_wenneb: RTL and testbench

Tiny Tapeout user tile implementing an 8-bit accumulator ALU. An external controller presents an operand on `ui_in`, an opcode and an execute strobe on `uio_in[4:0]`, and pulses the strobe. The block updates an internal accumulator and three status flags. The accumulator drives `uo_out`, and the flags drive `uio_out[7:5]`.

---
 rtl/tt_um_wenneb.sv | 156 +++++++++++++++
 tb/tb_tt_um_wenneb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_wenneb.sv
// tt_um_wenneb: 8-bit accumulator ALU tile.
// An external controller presents operand B on ui_in and an opcode on
// uio_in[3:0], then raises the execute strobe uio_in[4]. Each rising edge
// of the strobe (while ena is high) executes one operation on accumulator A
// and updates the Z/C/V flags.
// Optional feature macro: WENNEB_MUL_EN enables opcode F (8x8 multiply,
// low byte kept). Without it opcode F behaves as NOP and no multiplier exists.
module tt_um_wenneb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_INC  = 4'hC;
    localparam logic [3:0] OP_DEC  = 4'hD;
    localparam logic [3:0] OP_CLR  = 4'hE;
    localparam logic [3:0] OP_MUL  = 4'hF;

    logic [7:0] acc_q, acc_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       v_q, v_d;
    logic       strobe_q;

    logic [3:0] opcode;
    logic       exec;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic       unused_ok;

    assign opcode = uio_in[3:0];
    // Only a rising strobe edge executes, so a held strobe runs once.
    assign exec   = ena & uio_in[4] & ~strobe_q;
    assign sum9   = {1'b0, acc_q} + {1'b0, ui_in};
    assign diff9  = {1'b0, acc_q} - {1'b0, ui_in};

    // Upper uio_in bits carry no meaning for this tile.
    assign unused_ok = &{1'b0, uio_in[7:5]};

`ifdef WENNEB_MUL_EN
    logic [15:0] prod16;
    assign prod16 = acc_q * ui_in;
`endif

    // Next accumulator and flags for the current opcode; hold when not executing.
    always_comb begin
        acc_d = acc_q;
        z_d   = z_q;
        c_d   = c_q;
        v_d   = v_q;
        if (exec && (opcode != OP_NOP)) begin
            c_d = 1'b0;
            v_d = 1'b0;
            unique case (opcode)
                OP_LOAD: acc_d = ui_in;
                OP_ADD: begin
                    acc_d = sum9[7:0];
                    c_d   = sum9[8];
                    v_d   = (acc_q[7] == ui_in[7]) && (sum9[7] != acc_q[7]);
                end
                OP_SUB: begin
                    acc_d = diff9[7:0];
                    c_d   = diff9[8];
                    v_d   = (acc_q[7] != ui_in[7]) && (diff9[7] != acc_q[7]);
                end
                OP_AND: acc_d = acc_q & ui_in;
                OP_OR:  acc_d = acc_q | ui_in;
                OP_XOR: acc_d = acc_q ^ ui_in;
                OP_NOT: acc_d = ~acc_q;
                OP_SHL: begin
                    acc_d = {acc_q[6:0], 1'b0};
                    c_d   = acc_q[7];
                end
                OP_SHR: begin
                    acc_d = {1'b0, acc_q[7:1]};
                    c_d   = acc_q[0];
                end
                OP_ROL: begin
                    acc_d = {acc_q[6:0], acc_q[7]};
                    c_d   = acc_q[7];
                end
                OP_ROR: begin
                    acc_d = {acc_q[0], acc_q[7:1]};
                    c_d   = acc_q[0];
                end
                OP_INC: begin
                    acc_d = acc_q + 8'd1;
                    c_d   = (acc_q == 8'hFF);
                end
                OP_DEC: begin
                    acc_d = acc_q - 8'd1;
                    c_d   = (acc_q == 8'h00);
                end
                OP_CLR: acc_d = 8'h00;
`ifdef WENNEB_MUL_EN
                OP_MUL: begin
                    acc_d = prod16[7:0];
                    c_d   = (prod16[15:8] != 8'h00);
                end
`else
                OP_MUL: begin
                    c_d = c_q;
                    v_d = v_q;
                end
`endif
                default: ;
            endcase
`ifdef WENNEB_MUL_EN
            z_d = (acc_d == 8'h00);
`else
            if (opcode != OP_MUL) begin
                z_d = (acc_d == 8'h00);
            end
`endif
        end
    end

    // Accumulator, flag and strobe-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= 8'h00;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            strobe_q <= uio_in[4];
        end
    end

    assign uo_out  = acc_q;
    assign uio_out = {v_q, c_q, z_q, 5'b00000};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_wenneb.sv
// Directed bench for tt_um_wenneb. uio_out expectations are {V,C,Z,00000}.
module tb_tt_um_wenneb;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_errors = 0;

    tt_um_wenneb dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One strobe pulse: high for one clock, then low for one clock.
    task automatic run_op(input logic [3:0] op, input logic [7:0] b);
        ui_in  = b;
        uio_in = {3'b101, 1'b1, op};
        @(posedge clk); #1;
        uio_in[4] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hE0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_uo", uo_out, 8'h00);
        check("post_rst_uio", uio_out, 8'h00);

        run_op(4'h1, 8'h7F);
        check("load7f", uo_out, 8'h7F);
        run_op(4'h2, 8'h01);
        check("add_ovf_a", uo_out, 8'h80);
        check("add_ovf_f", uio_out, 8'h80);

        run_op(4'h1, 8'h01);
        run_op(4'h2, 8'hFF);
        check("add_zero_a", uo_out, 8'h00);
        check("add_zero_f", uio_out, 8'h60);

        run_op(4'h1, 8'h05);
        run_op(4'h3, 8'h07);
        check("sub_a", uo_out, 8'hFE);
        check("sub_f", uio_out, 8'h40);
        run_op(4'h1, 8'h80);
        run_op(4'h3, 8'h01);
        check("sub_ovf_a", uo_out, 8'h7F);
        check("sub_ovf_f", uio_out, 8'h80);

        run_op(4'hE, 8'h55);
        check("clr_a", uo_out, 8'h00);
        check("clr_f", uio_out, 8'h20);
        run_op(4'hD, 8'h00);
        check("dec_a", uo_out, 8'hFF);
        check("dec_f", uio_out, 8'h40);
        run_op(4'hC, 8'h00);
        check("inc_wrap_a", uo_out, 8'h00);
        check("inc_wrap_f", uio_out, 8'h60);

        // Strobe held high for five clocks executes INC once.
        run_op(4'h1, 8'h10);
        uio_in = {3'b000, 1'b1, 4'hC};
        repeat (5) @(posedge clk);
        #1;
        check("held_inc", uo_out, 8'h11);
        uio_in[4] = 1'b0;
        @(posedge clk); #1;

        // Edge while disabled is ignored, and enabling later with strobe high does nothing.
        ena = 1'b0;
        uio_in = {3'b000, 1'b1, 4'hC};
        @(posedge clk); #1;
        check("ena0_inc", uo_out, 8'h11);
        ena = 1'b1;
        @(posedge clk); #1;
        check("ena_late", uo_out, 8'h11);
        uio_in[4] = 1'b0;
        @(posedge clk); #1;

        run_op(4'h1, 8'h81);
        run_op(4'hA, 8'h00);
        check("rol_a", uo_out, 8'h03);
        check("rol_f", uio_out, 8'h40);
        run_op(4'h9, 8'h00);
        check("shr_a", uo_out, 8'h01);
        check("shr_f", uio_out, 8'h40);
        run_op(4'h0, 8'hAA);
        check("nop_a", uo_out, 8'h01);
        check("nop_f", uio_out, 8'h40);
        run_op(4'h7, 8'h00);
        check("not_a", uo_out, 8'hFE);
        check("not_f", uio_out, 8'h00);

        run_op(4'h1, 8'hC0);
        run_op(4'h8, 8'h00);
        check("shl_a", uo_out, 8'h80);
        check("shl_f", uio_out, 8'h40);
        run_op(4'h1, 8'h01);
        run_op(4'hB, 8'h00);
        check("ror_a", uo_out, 8'h80);
        check("ror_f", uio_out, 8'h40);

        run_op(4'h1, 8'hF0);
        run_op(4'h4, 8'h3C);
        check("and_a", uo_out, 8'h30);
        run_op(4'h5, 8'h0F);
        check("or_a", uo_out, 8'h3F);
        run_op(4'h6, 8'hFF);
        check("xor_a", uo_out, 8'hC0);
        check("xor_f", uio_out, 8'h00);

        // Opcode F with A=20, B=10; flags preset to C=1 by SHL of A0 then ROR... keep simple: LOAD.
        run_op(4'h1, 8'h20);
        run_op(4'hF, 8'h10);
`ifdef WENNEB_MUL_EN
        check("mul_a", uo_out, 8'h00);
        check("mul_f", uio_out, 8'h60);
`else
        check("opf_a", uo_out, 8'h20);
        check("opf_f", uio_out, 8'h00);
`endif

        // Asynchronous reset mid-cycle clears state immediately.
        run_op(4'h1, 8'hFF);
        run_op(4'hC, 8'h00);
        check("pre_rst_f", uio_out, 8'h60);
        ui_in  = 8'h5A;
        uio_in = {3'b000, 1'b1, 4'h1};
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a", uo_out, 8'h00);
        check("async_rst_f", uio_out, 8'h00);
        @(posedge clk); #1;
        check("in_rst_a", uo_out, 8'h00);
        // Strobe held high across release executes on the first clock.
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_exec_a", uo_out, 8'h5A);
        check("rel_exec_f", uio_out, 8'h00);
        @(posedge clk); #1;
        check("rel_once_a", uo_out, 8'h5A);
        uio_in[4] = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
